// File: rtl/mb_conf_builder_pkg.sv
// Shared types and sizes for the macroblock sign-count configuration path.
package sign_pkg;

  localparam int unsigned CNT_W        = 7;
  localparam int unsigned NUM_GROUPS   = 6;
  localparam int unsigned NUM_FIELDS   = 2 * NUM_GROUPS + 1;
  localparam int unsigned MB_CONF_W    = CNT_W * NUM_FIELDS;
  localparam int unsigned FIELD_MOTION = 0;

  typedef struct packed {
    logic       last;
    logic       selected;
    logic       rsvd;
    logic [2:0] group;
  } sym_info_t;

  typedef enum logic {S_RUN, S_HOLD} state_t;

  // Field 0 is motion; group g maps to 2g-1 (selected) and 2g (unselected).
  function automatic logic [3:0] field_idx(input logic [2:0] group, input logic selected);
    if (group == 3'd0) return 4'(FIELD_MOTION);
    return {group, 1'b0} - 4'd1 + {3'b000, ~selected};
  endfunction

endpackage

// File: rtl/mb_conf_builder_group_scan.sv
// Combinational scan of a packed count snapshot: lowest active index and single-index flag.
module group_scan
  import sign_pkg::*;
(
  input  logic [MB_CONF_W-1:0] i_mb_conf,
  output logic [2:0]           o_first_group,
  output logic                 o_has_one_group
);

  logic [NUM_GROUPS:0] w_nz;
  logic                w_seen;
  logic                w_multi;

  always_comb begin
    w_nz    = '0;
    w_nz[0] = |i_mb_conf[MB_CONF_W-1 -: CNT_W];
    for (int unsigned g = 1; g <= NUM_GROUPS; g++) begin
      w_nz[g] = (|i_mb_conf[MB_CONF_W-1-CNT_W*(2*g-1) -: CNT_W]) |
                (|i_mb_conf[MB_CONF_W-1-CNT_W*(2*g) -: CNT_W]);
    end
  end

  always_comb begin
    o_first_group = '0;
    w_seen        = 1'b0;
    w_multi       = 1'b0;
    for (int unsigned g = 0; g <= NUM_GROUPS; g++) begin
      if (w_nz[g]) begin
        if (!w_seen) o_first_group = 3'(g);
        else         w_multi       = 1'b1;
        w_seen = 1'b1;
      end
    end
    o_has_one_group = w_seen & ~w_multi;
  end

endmodule

// File: rtl/mb_conf_builder.sv
// Counts per-macroblock signs from the symbol FIFO and emits one mb_conf word per MB.
// Optional build macro MB_CONF_SAT_EN: saturating counts with sticky cnt_ovf.
module mb_conf_builder
  import sign_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_en,
  input  logic [5:0]           sym_info,
  input  logic                 sym_empty,
  output logic                 sym_rd,
  input  logic                 mb_conf_afull,
  output logic [MB_CONF_W-1:0] mb_conf,
  output logic [2:0]           first_group,
  output logic                 has_one_group,
  output logic                 mb_conf_wr,
  output logic                 cnt_ovf,
  output logic                 illegal_grp
);

  sym_info_t            w_sym;
  logic                 w_unused_rsvd;
  logic                 r_rd_q;
  logic                 w_take;
  logic                 w_take_last;
  logic                 w_legal;
  logic [3:0]           w_fidx;
  logic [CNT_W-1:0]     r_cnt     [NUM_FIELDS];
  logic [CNT_W-1:0]     w_cnt_nxt [NUM_FIELDS];
  logic [MB_CONF_W-1:0] r_snap;
  logic [MB_CONF_W-1:0] w_snap_nxt;
  logic                 r_illegal;
  state_t               r_state;
  state_t               w_state_nxt;

  assign w_sym         = sym_info_t'(sym_info);
  assign w_unused_rsvd = w_sym.rsvd;
  assign w_take        = r_rd_q & clk_en;
  assign w_take_last   = w_take & w_sym.last;
  assign w_legal       = (w_sym.group != 3'd7);
  assign w_fidx        = field_idx(w_sym.group, w_sym.selected);

`ifdef MB_CONF_SAT_EN
  logic w_ovf_hit;
  logic r_ovf;

  always_comb begin
    w_cnt_nxt = r_cnt;
    w_ovf_hit = 1'b0;
    if (w_take && w_legal) begin
      if (r_cnt[w_fidx] == '1) w_ovf_hit = 1'b1;
      else                     w_cnt_nxt[w_fidx] = r_cnt[w_fidx] + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           r_ovf <= 1'b0;
    else if (w_ovf_hit) r_ovf <= 1'b1;
  end

  assign cnt_ovf = r_ovf;
`else
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_take && w_legal) w_cnt_nxt[w_fidx] = r_cnt[w_fidx] + 1'b1;
  end

  assign cnt_ovf = 1'b0;
`endif

  // Snapshot includes the symbol being captured, so the last word is never lost.
  always_comb begin
    w_snap_nxt = '0;
    for (int unsigned f = 0; f < NUM_FIELDS; f++) begin
      w_snap_nxt[MB_CONF_W-1-CNT_W*f -: CNT_W] = w_cnt_nxt[f];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_q    <= 1'b0;
      r_cnt     <= '{default: '0};
      r_snap    <= '0;
      r_illegal <= 1'b0;
    end else if (clk_en) begin
      r_rd_q <= sym_rd;
      if (w_take_last) begin
        r_snap <= w_snap_nxt;
        r_cnt  <= '{default: '0};
      end else begin
        r_cnt  <= w_cnt_nxt;
      end
      if (w_take && !w_legal) r_illegal <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_RUN;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN:  if (w_take_last)               w_state_nxt = S_HOLD;
      S_HOLD: if (clk_en && !mb_conf_afull)  w_state_nxt = S_RUN;
      default:                               w_state_nxt = S_RUN;
    endcase
  end

  // A read is suppressed while a last word is on the bus so the next MB cannot start during HOLD.
  always_comb begin
    sym_rd     = (r_state == S_RUN) & clk_en & ~sym_empty & ~(r_rd_q & w_sym.last);
    mb_conf_wr = (r_state == S_HOLD) & clk_en & ~mb_conf_afull;
  end

  group_scan u_scan (
    .i_mb_conf       (r_snap),
    .o_first_group   (first_group),
    .o_has_one_group (has_one_group)
  );

  assign mb_conf     = r_snap;
  assign illegal_grp = r_illegal;

endmodule
